fir_coef_loader: RTL and testbench

AXI4-Lite master that configures and starts the `my_fir_v1_0` filter without processor intervention. On a `start` pulse it halts the filter (CTRL = 0), streams TAPS coefficients from an external synchronous ROM into coefficient registers 1..TAPS, optionally reads each one back and compares it, then writes CTRL = 1 to enable filtering. It sits between a boot/config source and the FIR's `s_axi` slave port.

---
 rtl/fir_coef_loader_if.sv | 41 ++++
 rtl/fir_coef_loader.sv | 191 +++++++++++++++++++
 tb/tb_fir_coef_loader.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_coef_loader_if.sv
// AXI4-Lite channel bundle between the coefficient loader (master) and the FIR s_axi port (slave).
interface fir_coef_loader_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic [ADDR_W-1:0]   awaddr;
   logic [2:0]          awprot;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ADDR_W-1:0]   araddr;
   logic [2:0]          arprot;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input rdata, rresp, rvalid, output rready
   );

   modport slave (
      input awaddr, awprot, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/fir_coef_loader.sv
// AXI4-Lite master that halts the FIR, loads TAPS coefficients from a sync ROM,
// optionally verifies each by readback, then re-enables the filter.
module fir_coef_loader #(
   parameter int unsigned TAPS               = 53,
   parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
   parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
   parameter int unsigned COEF_WIDTH         = 16,
   parameter bit          VERIFY             = 1'b1,
   parameter int unsigned CTRL_ADDR          = 0,
   localparam int unsigned IDX_W             = $clog2(TAPS + 1)
) (
   input  logic                  m_axi_aclk,
   input  logic                  m_axi_areset,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [1:0]            err_code,
   output logic [7:0]            err_index,
   output logic                  coef_rd_en,
   output logic [IDX_W-1:0]      coef_rd_addr,
   input  logic [COEF_WIDTH-1:0] coef_rd_data,
   fir_coef_loader_if.master     m_axi
);

   typedef enum logic [3:0] {
      S_IDLE, S_STOP_WR, S_STOP_RESP, S_FETCH, S_LATCH, S_WR, S_RESP,
      S_RD, S_RDATA, S_START_WR, S_START_RESP, S_DONE, S_ERR
   } state_t;

   state_t                        state_q, state_d;
   logic [IDX_W-1:0]              index_q, index_d;
   logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                          aw_ok_q, aw_ok_d;
   logic                          w_ok_q, w_ok_d;
   logic                          error_q, error_d;
   logic [1:0]                    err_code_q, err_code_d;
   logic [7:0]                    err_index_q, err_index_d;
   logic [C_M_AXI_ADDR_WIDTH-1:0] idx_addr;
   logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr;
   logic                          last_idx;

   assign idx_addr  = C_M_AXI_ADDR_WIDTH'({index_q, 2'b00});
   assign ctrl_addr = C_M_AXI_ADDR_WIDTH'(CTRL_ADDR << 2);
   assign last_idx  = (index_q == IDX_W'(TAPS));

   assign m_axi.awprot = '0;
   assign m_axi.arprot = '0;
   assign m_axi.wstrb  = '1;
   assign error        = error_q;
   assign err_code     = err_code_q;
   assign err_index    = err_index_q;
   assign coef_rd_addr = index_q;

   always_ff @(posedge m_axi_aclk) begin
      if (m_axi_areset) begin
         state_q     <= S_IDLE;
         index_q     <= '0;
         wdata_q     <= '0;
         aw_ok_q     <= 1'b0;
         w_ok_q      <= 1'b0;
         error_q     <= 1'b0;
         err_code_q  <= '0;
         err_index_q <= '0;
      end else begin
         state_q     <= state_d;
         index_q     <= index_d;
         wdata_q     <= wdata_d;
         aw_ok_q     <= aw_ok_d;
         w_ok_q      <= w_ok_d;
         error_q     <= error_d;
         err_code_q  <= err_code_d;
         err_index_q <= err_index_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      index_d       = index_q;
      wdata_d       = wdata_q;
      aw_ok_d       = aw_ok_q;
      w_ok_d        = w_ok_q;
      error_d       = error_q;
      err_code_d    = err_code_q;
      err_index_d   = err_index_q;
      busy          = 1'b1;
      done          = 1'b0;
      coef_rd_en    = 1'b0;
      m_axi.awaddr  = '0;
      m_axi.awvalid = 1'b0;
      m_axi.wdata   = '0;
      m_axi.wvalid  = 1'b0;
      m_axi.bready  = 1'b0;
      m_axi.araddr  = '0;
      m_axi.arvalid = 1'b0;
      m_axi.rready  = 1'b0;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            busy    = 1'b0;
            done    = (state_q == S_DONE);
            state_d = S_IDLE;
            if (start) begin
               state_d     = S_STOP_WR;
               index_d     = IDX_W'(1);
               error_d     = 1'b0;
               err_code_d  = '0;
               err_index_d = '0;
            end
         end
         // AW and W complete independently; the ok flags remember whichever finished first.
         S_STOP_WR, S_WR, S_START_WR: begin
            m_axi.awvalid = ~aw_ok_q;
            m_axi.wvalid  = ~w_ok_q;
            if (state_q == S_WR) begin
               m_axi.awaddr = idx_addr;
               m_axi.wdata  = wdata_q;
            end else begin
               m_axi.awaddr = ctrl_addr;
               m_axi.wdata  = (state_q == S_START_WR) ? C_M_AXI_DATA_WIDTH'(1) : '0;
            end
            aw_ok_d = aw_ok_q | m_axi.awready;
            w_ok_d  = w_ok_q | m_axi.wready;
            if (aw_ok_d && w_ok_d) begin
               aw_ok_d = 1'b0;
               w_ok_d  = 1'b0;
               if (state_q == S_WR)           state_d = S_RESP;
               else if (state_q == S_STOP_WR) state_d = S_STOP_RESP;
               else                           state_d = S_START_RESP;
            end
         end
         S_STOP_RESP, S_RESP, S_START_RESP: begin
            m_axi.bready = 1'b1;
            if (m_axi.bvalid) begin
               if (m_axi.bresp != 2'b00) begin
                  state_d     = S_ERR;
                  error_d     = 1'b1;
                  err_code_d  = 2'd1;
                  err_index_d = (state_q == S_RESP) ? 8'(index_q) : 8'(CTRL_ADDR);
               end else if (state_q == S_STOP_RESP) begin
                  state_d = S_FETCH;
               end else if (state_q == S_START_RESP) begin
                  state_d = S_DONE;
               end else if (VERIFY) begin
                  state_d = S_RD;
               end else if (last_idx) begin
                  state_d = S_START_WR;
               end else begin
                  index_d = index_q + IDX_W'(1);
                  state_d = S_FETCH;
               end
            end
         end
         S_FETCH: begin
            coef_rd_en = 1'b1;
            state_d    = S_LATCH;
         end
         S_LATCH: begin
            wdata_d = C_M_AXI_DATA_WIDTH'(coef_rd_data);
            state_d = S_WR;
         end
         S_RD: begin
            m_axi.arvalid = 1'b1;
            m_axi.araddr  = idx_addr;
            if (m_axi.arready) state_d = S_RDATA;
         end
         S_RDATA: begin
            m_axi.rready = 1'b1;
            if (m_axi.rvalid) begin
               if (m_axi.rresp != 2'b00 || m_axi.rdata != wdata_q) begin
                  state_d     = S_ERR;
                  error_d     = 1'b1;
                  err_code_d  = (m_axi.rresp != 2'b00) ? 2'd2 : 2'd3;
                  err_index_d = 8'(index_q);
               end else if (last_idx) begin
                  state_d = S_START_WR;
               end else begin
                  index_d = index_q + IDX_W'(1);
                  state_d = S_FETCH;
               end
            end
         end
         S_ERR: begin
            busy    = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader: AXI-Lite slave models with configurable stalls/faults and a sync ROM.
module tb_fir_coef_loader;
   localparam int unsigned TAPS = 53;
   localparam int unsigned IW   = $clog2(TAPS + 1);

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- DUT0: VERIFY=1 ----------------
   logic          start0, busy0, done0, error0, rd_en0;
   logic [1:0]    err_code0;
   logic [7:0]    err_index0;
   logic [IW-1:0] rd_addr0;
   logic [15:0]   rom0;
   fir_coef_loader_if #(.ADDR_W(32), .DATA_W(32)) ax0 ();

   fir_coef_loader #(
      .TAPS(TAPS), .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32),
      .COEF_WIDTH(16), .VERIFY(1'b1), .CTRL_ADDR(0)
   ) dut0 (
      .m_axi_aclk(clk), .m_axi_areset(rst), .start(start0), .busy(busy0),
      .done(done0), .error(error0), .err_code(err_code0), .err_index(err_index0),
      .coef_rd_en(rd_en0), .coef_rd_addr(rd_addr0), .coef_rd_data(rom0), .m_axi(ax0)
   );

   int cfg_aw_dly = 0, cfg_w_dly = 0, cfg_berr = -1, cfg_bad = -1;
   int aw_wait, w_wait, viol, wonly, awonly;
   logic aw_got, w_got, ar_pend, b_fire, r_fire, aw_hold, w_hold;
   logic [31:0] aw_addr, w_data, ar_addr;
   logic [31:0] mem [0:63];
   logic [31:0] wq_addr[$], wq_data[$], arq[$];

   // Slave outputs change on the falling edge; handshakes land on the following rising edge.
   always @(negedge clk) begin
      if (rst) begin
         ax0.awready = 1'b0; ax0.wready = 1'b0; ax0.bvalid = 1'b0; ax0.bresp = 2'b00;
         ax0.arready = 1'b0; ax0.rvalid = 1'b0; ax0.rresp = 2'b00; ax0.rdata = '0;
         aw_got = 1'b0; w_got = 1'b0; ar_pend = 1'b0; b_fire = 1'b0; r_fire = 1'b0;
         aw_hold = 1'b0; w_hold = 1'b0; aw_wait = cfg_aw_dly; w_wait = cfg_w_dly;
         rom0 = '0;
      end else begin
         if (b_fire) ax0.bvalid = 1'b0;
         if (r_fire) ax0.rvalid = 1'b0;
         if (aw_hold && !ax0.awvalid) viol++;
         if (w_hold && !ax0.wvalid) viol++;
         if (aw_got && w_got) begin
            wq_addr.push_back(aw_addr);
            wq_data.push_back(w_data);
            mem[aw_addr[7:2]] = w_data;
            ax0.bresp  = (int'(aw_addr[7:2]) == cfg_berr) ? 2'b10 : 2'b00;
            ax0.bvalid = 1'b1;
            aw_got = 1'b0;
            w_got  = 1'b0;
         end
         if (ax0.awvalid && aw_got) viol++;
         if (ax0.wvalid && w_got) viol++;
         if (ax0.wvalid && !ax0.awvalid) wonly++;
         if (ax0.awvalid && !ax0.wvalid) awonly++;
         ax0.awready = 1'b0;
         if (ax0.awvalid && !aw_got) begin
            if (aw_wait == 0) begin ax0.awready = 1'b1; aw_got = 1'b1; aw_addr = ax0.awaddr; end
            else aw_wait--;
         end else aw_wait = cfg_aw_dly;
         ax0.wready = 1'b0;
         if (ax0.wvalid && !w_got) begin
            if (w_wait == 0) begin ax0.wready = 1'b1; w_got = 1'b1; w_data = ax0.wdata; end
            else w_wait--;
         end else w_wait = cfg_w_dly;
         if (ar_pend) begin
            ax0.rvalid = 1'b1;
            ax0.rresp  = 2'b00;
            ax0.rdata  = (int'(ar_addr[7:2]) == cfg_bad) ? 32'hFFFF : mem[ar_addr[7:2]];
            ar_pend    = 1'b0;
         end
         ax0.arready = 1'b0;
         if (ax0.arvalid && !ax0.rvalid) begin
            ax0.arready = 1'b1;
            ar_pend = 1'b1;
            ar_addr = ax0.araddr;
            arq.push_back(ax0.araddr);
         end
         aw_hold = ax0.awvalid && !ax0.awready;
         w_hold  = ax0.wvalid && !ax0.wready;
         b_fire  = ax0.bvalid && ax0.bready;
         r_fire  = ax0.rvalid && ax0.rready;
         if (rd_en0) rom0 = 16'(rd_addr0);
      end
   end

   // ---------------- DUT1: VERIFY=0 ----------------
   logic          start1, busy1, done1, error1, rd_en1;
   logic [1:0]    err_code1;
   logic [7:0]    err_index1;
   logic [IW-1:0] rd_addr1;
   logic [15:0]   rom1;
   fir_coef_loader_if #(.ADDR_W(32), .DATA_W(32)) ax1 ();

   fir_coef_loader #(
      .TAPS(TAPS), .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32),
      .COEF_WIDTH(16), .VERIFY(1'b0), .CTRL_ADDR(0)
   ) dut1 (
      .m_axi_aclk(clk), .m_axi_areset(rst), .start(start1), .busy(busy1),
      .done(done1), .error(error1), .err_code(err_code1), .err_index(err_index1),
      .coef_rd_en(rd_en1), .coef_rd_addr(rd_addr1), .coef_rd_data(rom1), .m_axi(ax1)
   );

   int n_wr1 = 0, n_ar1 = 0, n_done1 = 0, sum1 = 0;
   logic got1, b1_fire;
   logic [31:0] last_a1, last_d1;

   always @(negedge clk) begin
      ax1.awready = 1'b1; ax1.wready = 1'b1; ax1.arready = 1'b1; ax1.bresp = 2'b00;
      ax1.rvalid = 1'b0; ax1.rresp = 2'b00; ax1.rdata = '0;
      if (rst) begin
         ax1.bvalid = 1'b0; got1 = 1'b0; b1_fire = 1'b0; rom1 = '0;
      end else begin
         if (b1_fire) ax1.bvalid = 1'b0;
         if (got1) begin ax1.bvalid = 1'b1; got1 = 1'b0; end
         if (ax1.awvalid && ax1.wvalid) begin
            got1 = 1'b1; n_wr1++; sum1 += int'(ax1.wdata);
            last_a1 = ax1.awaddr; last_d1 = ax1.wdata;
         end
         if (ax1.arvalid) n_ar1++;
         if (done1) n_done1++;
         if (rd_en1) rom1 = 16'(rd_addr1);
         b1_fire = ax1.bvalid && ax1.bready;
      end
   end

   // ---------------- helpers ----------------
   task automatic clear_logs();
      wq_addr.delete(); wq_data.delete(); arq.delete();
      viol = 0; wonly = 0; awonly = 0;
   endtask

   task automatic run0(input string tag, output int lat);
      int c0;
      lat = -1;
      @(negedge clk); start0 = 1'b1; c0 = cyc;
      @(negedge clk); start0 = 1'b0;
      chk({tag, "_busy_rise"}, busy0, 1'b1);
      chk({tag, "_err_clr"}, error0, 1'b0);
      for (int i = 0; i < 3000 && lat < 0; i++) begin
         if (done0 || error0) lat = cyc - c0;
         else @(negedge clk);
      end
   endtask

   task automatic chk_writes(input string tag, input int ncoef, input bit with_start);
      int nb, n_exp;
      logic [31:0] ea, ed;
      nb = 0;
      n_exp = ncoef + 1 + int'(with_start);
      chk({tag, "_nwr"}, wq_addr.size(), n_exp);
      if (wq_addr.size() != n_exp) nb = -1;
      else begin
         for (int i = 0; i < n_exp; i++) begin
            if (i == 0)          begin ea = 32'h0;     ed = 32'h0;   end
            else if (i <= ncoef) begin ea = 32'(i * 4); ed = 32'(i); end
            else                 begin ea = 32'h0;     ed = 32'h1;   end
            if (wq_addr[i] !== ea || wq_data[i] !== ed) nb++;
         end
      end
      chk({tag, "_wseq"}, nb, 0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: sim time exceeded, got no end expected finish");
      $fatal(1);
   end

   initial begin
      int lat, c0, found;
      rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
      clear_logs();
      repeat (3) @(negedge clk);
      chk("rst_busy", busy0, 1'b0);
      chk("rst_done", done0, 1'b0);
      chk("rst_error", error0, 1'b0);
      chk("rst_err_code", err_code0, 2'd0);
      chk("rst_err_index", err_index0, 8'd0);
      chk("rst_valids", {ax0.awvalid, ax0.wvalid, ax0.arvalid}, 3'b000);
      chk("rst_readies", {ax0.bready, ax0.rready}, 2'b00);
      chk("rst_rd_en", rd_en0, 1'b0);
      chk("rst_addr_data", {ax0.awaddr, ax0.araddr, ax0.wdata}, 96'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // zero-wait full sequence
      clear_logs();
      run0("t1", lat);
      chk("t1_latency", lat, 323);
      chk("t1_done_busy", busy0, 1'b0);
      chk("t1_error", error0, 1'b0);
      chk_writes("t1", 53, 1'b1);
      chk("t1_nreads", arq.size(), 53);
      chk("t1_protocol", viol, 0);
      @(negedge clk);
      chk("t1_done_pulse", done0, 1'b0);

      // W lags AW by 3 cycles
      cfg_aw_dly = 0; cfg_w_dly = 3;
      clear_logs();
      run0("t2", lat);
      chk("t2_error", error0, 1'b0);
      chk_writes("t2", 53, 1'b1);
      chk("t2_protocol", viol, 0);
      chk("t2_w_held_alone", wonly > 0, 1'b1);

      // AW lags W by 3 cycles
      cfg_aw_dly = 3; cfg_w_dly = 0;
      clear_logs();
      run0("t3", lat);
      chk("t3_error", error0, 1'b0);
      chk_writes("t3", 53, 1'b1);
      chk("t3_protocol", viol, 0);
      chk("t3_aw_held_alone", awonly > 0, 1'b1);

      // corrupted readback at word 7
      cfg_aw_dly = 0; cfg_w_dly = 0; cfg_bad = 7;
      clear_logs();
      run0("t4", lat);
      chk("t4_error", error0, 1'b1);
      chk("t4_err_code", err_code0, 2'd3);
      chk("t4_err_index", err_index0, 8'd7);
      chk("t4_busy", busy0, 1'b0);
      chk_writes("t4", 7, 1'b0);
      cfg_bad = -1;
      repeat (3) @(negedge clk);
      chk("t4_error_sticky", error0, 1'b1);

      // SLVERR on word 20
      cfg_berr = 20;
      clear_logs();
      run0("t5", lat);
      chk("t5_error", error0, 1'b1);
      chk("t5_err_code", err_code0, 2'd1);
      chk("t5_err_index", err_index0, 8'd20);
      chk_writes("t5", 20, 1'b0);
      chk("t5_nreads", arq.size(), 19);
      chk("t5_last_read", (arq.size() > 0) ? arq[arq.size() - 1] : 32'hDEAD, 32'h4C);
      cfg_berr = -1;
      repeat (3) @(negedge clk);

      // reset while the first coefficient write is stalled
      cfg_aw_dly = 50; cfg_w_dly = 50;
      clear_logs();
      @(negedge clk); start0 = 1'b1;
      @(negedge clk); start0 = 1'b0;
      found = 0;
      for (int i = 0; i < 500 && found == 0; i++) begin
         @(negedge clk);
         if (ax0.awvalid && ax0.awaddr == 32'h4) found = 1;
      end
      chk("t6_reach_wr", found, 1);
      @(negedge clk);
      chk("t6_stalled", ax0.awvalid && !ax0.awready, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_awvalid", ax0.awvalid, 1'b0);
      chk("t6_wvalid", ax0.wvalid, 1'b0);
      chk("t6_busy", busy0, 1'b0);
      cfg_aw_dly = 0; cfg_w_dly = 0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      clear_logs();
      run0("t6", lat);
      chk("t6_latency", lat, 323);
      chk("t6_error", error0, 1'b0);
      chk_writes("t6", 53, 1'b1);

      // VERIFY=0 with start pulsed repeatedly while busy
      @(negedge clk); start1 = 1'b1; c0 = cyc;
      @(negedge clk); start1 = 1'b0;
      lat = -1;
      for (int i = 1; i < 600 && lat < 0; i++) begin
         if (done1) lat = cyc - c0;
         else begin
            start1 = (i % 10 == 0 && i <= 150) ? 1'b1 : 1'b0;
            @(negedge clk);
         end
      end
      start1 = 1'b0;
      chk("t7_latency", lat, 217);
      repeat (30) @(negedge clk);
      chk("t7_ndone", n_done1, 1);
      chk("t7_busy", busy1, 1'b0);
      chk("t7_error", error1, 1'b0);
      chk("t7_nreads", n_ar1, 0);
      chk("t7_nwrites", n_wr1, 55);
      chk("t7_wdata_sum", sum1, 1432);
      chk("t7_last_write", {last_a1, last_d1}, {32'h0, 32'h1});

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
